// File: rtl/corevx_tlb_pkg.sv
// corevx_tlb_pkg: shared encodings for the corevx TLB.
// Holds request command codes, PTE access-bit positions and FSM state type.
package corevx_tlb_pkg;

    // req_cmd encodings (2'b00 is reserved and handled as a read)
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_EXEC  = 2'b11;

    // PTE access bit positions within bits[7:0]
    localparam int AB_V = 0;
    localparam int AB_R = 1;
    localparam int AB_W = 2;
    localparam int AB_X = 3;
    localparam int AB_U = 4;
    localparam int AB_G = 5;
    localparam int AB_A = 6;
    localparam int AB_D = 7;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOOKUP      = 2'd1,
        ST_REFILL_REQ  = 2'd2,
        ST_REFILL_WAIT = 2'd3
    } tlb_state_e;

endpackage

// File: rtl/corevx_tlb_perm_check.sv
// corevx_tlb_perm_check: combinational Sv32 permission check.
// Shared by the hit path and the refill path of corevx_tlb.
module corevx_tlb_perm_check
    import corevx_tlb_pkg::*;
(
    input  logic [1:0] cmd,
    input  logic       user,
    input  logic       perm_r,
    input  logic       perm_w,
    input  logic       perm_x,
    input  logic       perm_u,
    input  logic       perm_a,
    input  logic       perm_d,
    output logic       pagefault
);

    logic is_write;
    logic is_exec;
    logic is_read;

    // Reserved command 00 falls through to the read check.
    always_comb begin
        is_write  = (cmd == CMD_WRITE);
        is_exec   = (cmd == CMD_EXEC);
        is_read   = !is_write && !is_exec;
        pagefault = (is_read  && !perm_r)
                 || (is_write && !(perm_w && perm_d))
                 || (is_exec  && !perm_x)
                 || !perm_a
                 || (user != perm_u);
    end

endmodule

// File: rtl/corevx_tlb.sv
// corevx_tlb: direct-mapped Sv32 TLB with PTW refill controller.
// Optional feature macro: COREVX_TLB_STATS_EN adds stat_hits/stat_misses counters.
//
// state          | meaning
// ST_IDLE        | ready for a request (blocked while flush is high)
// ST_LOOKUP      | compare latched VPN against the indexed entry
// ST_REFILL_REQ  | holding PTW resolve request until ack
// ST_REFILL_WAIT | waiting for PTW done; respond and possibly install
module corevx_tlb
    import corevx_tlb_pkg::*;
#(
    parameter int ENTRIES_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [19:0] req_vpn,
    input  logic [1:0]  req_cmd,
    input  logic        req_user,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [21:0] resp_ppn,
    output logic [7:0]  resp_access_bits,
    output logic        resp_pagefault,
    output logic        resp_accessfault,
    input  logic        satp_mode,
    input  logic        flush,
    output logic        ptw_resolve_request,
    input  logic        ptw_resolve_ack,
    output logic [19:0] ptw_virtual_address,
    input  logic        ptw_resolve_done,
    input  logic        ptw_resolve_pagefault,
    input  logic        ptw_resolve_accessfault,
    input  logic [7:0]  ptw_resolve_access_bits,
    input  logic [21:0] ptw_resolve_physical_address
`ifdef COREVX_TLB_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int ENTRIES = 1 << ENTRIES_W;
    localparam int TAG_W   = 20 - ENTRIES_W;

    tlb_state_e            state;
    logic [19:0]           cur_vpn;
    logic [1:0]            cur_cmd;
    logic                  cur_user;
    logic                  flush_seen;
    logic [21:0]           last_ppn;
    logic [7:0]            last_bits;

    logic [ENTRIES-1:0]    valid;
    logic [TAG_W-1:0]      tag_mem  [ENTRIES];
    logic [21:0]           ppn_mem  [ENTRIES];
    logic [7:0]            bits_mem [ENTRIES];

    logic [ENTRIES_W-1:0]  idx;
    logic                  hit;
    logic                  fill;
    logic                  use_perm;
    logic                  ptw_pf;
    logic                  ptw_af;
    logic                  perm_pf;
    logic [21:0]           sel_ppn;
    logic [7:0]            sel_bits;

    assign idx                 = cur_vpn[ENTRIES_W-1:0];
    assign hit                 = valid[idx] && (tag_mem[idx] == cur_vpn[19:ENTRIES_W]);
    assign req_ready           = (state == ST_IDLE) && !flush;
    assign ptw_resolve_request = (state == ST_REFILL_REQ);
    assign ptw_virtual_address = cur_vpn;
    assign resp_ppn            = sel_ppn;
    assign resp_access_bits    = sel_bits;
    assign resp_accessfault    = ptw_af;
    assign resp_pagefault      = !ptw_af && (ptw_pf || (use_perm && perm_pf));

    // Response selection; outside a response the last delivered values are held.
    always_comb begin
        resp_valid = 1'b0;
        sel_ppn    = last_ppn;
        sel_bits   = last_bits;
        use_perm   = 1'b0;
        ptw_pf     = 1'b0;
        ptw_af     = 1'b0;
        fill       = 1'b0;
        case (state)
            ST_LOOKUP: begin
                if (!satp_mode) begin
                    resp_valid = 1'b1;
                    sel_ppn    = {2'b00, cur_vpn};
                    sel_bits   = 8'hFF;
                end else if (hit) begin
                    resp_valid = 1'b1;
                    sel_ppn    = ppn_mem[idx];
                    sel_bits   = bits_mem[idx];
                    use_perm   = 1'b1;
                end
            end
            ST_REFILL_WAIT: begin
                if (ptw_resolve_done) begin
                    resp_valid = 1'b1;
                    sel_ppn    = ptw_resolve_physical_address;
                    sel_bits   = ptw_resolve_access_bits;
                    if (ptw_resolve_accessfault) begin
                        ptw_af = 1'b1;
                    end else if (ptw_resolve_pagefault) begin
                        ptw_pf = 1'b1;
                    end else begin
                        use_perm = 1'b1;
                        fill     = !flush && !flush_seen;
                    end
                end
            end
            default: ;
        endcase
    end

    corevx_tlb_perm_check u_perm_check (
        .cmd       (cur_cmd),
        .user      (cur_user),
        .perm_r    (sel_bits[AB_R]),
        .perm_w    (sel_bits[AB_W]),
        .perm_x    (sel_bits[AB_X]),
        .perm_u    (sel_bits[AB_U]),
        .perm_a    (sel_bits[AB_A]),
        .perm_d    (sel_bits[AB_D]),
        .pagefault (perm_pf)
    );

    // Request/refill FSM with latched request and held response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_vpn    <= '0;
            cur_cmd    <= '0;
            cur_user   <= 1'b0;
            flush_seen <= 1'b0;
            last_ppn   <= '0;
            last_bits  <= '0;
        end else begin
            if (resp_valid) begin
                last_ppn  <= sel_ppn;
                last_bits <= sel_bits;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cur_vpn    <= req_vpn;
                        cur_cmd    <= req_cmd;
                        cur_user   <= req_user;
                        flush_seen <= 1'b0;
                        state      <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!satp_mode || hit) state <= ST_IDLE;
                    else                   state <= ST_REFILL_REQ;
                end
                ST_REFILL_REQ: begin
                    if (flush) flush_seen <= 1'b1;
                    if (ptw_resolve_ack) state <= ST_REFILL_WAIT;
                end
                ST_REFILL_WAIT: begin
                    if (flush) flush_seen <= 1'b1;
                    if (ptw_resolve_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Valid bits: flush clears everything and wins over a same-cycle install.
    always_ff @(posedge clk) begin
        if (rst)        valid      <= '0;
        else if (flush) valid      <= '0;
        else if (fill)  valid[idx] <= 1'b1;
    end

    // Entry payload storage, written only on a clean refill.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= cur_vpn[19:ENTRIES_W];
            ppn_mem[idx]  <= ptw_resolve_physical_address;
            bits_mem[idx] <= ptw_resolve_access_bits;
        end
    end

`ifdef COREVX_TLB_STATS_EN
    // Hit/miss counters for translated lookups only; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == ST_LOOKUP && satp_mode) begin
            if (hit) stat_hits   <= stat_hits + 32'd1;
            else     stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_corevx_tlb.sv
// tb_corevx_tlb: directed self-checking bench for corevx_tlb with a scripted PTW.
module tb_corevx_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [19:0] req_vpn;
    logic [1:0]  req_cmd;
    logic        req_user;
    logic        req_ready;
    logic        resp_valid;
    logic [21:0] resp_ppn;
    logic [7:0]  resp_access_bits;
    logic        resp_pagefault;
    logic        resp_accessfault;
    logic        satp_mode;
    logic        flush;
    logic        ptw_resolve_request;
    logic        ptw_resolve_ack;
    logic [19:0] ptw_virtual_address;
    logic        ptw_resolve_done;
    logic        ptw_resolve_pagefault;
    logic        ptw_resolve_accessfault;
    logic [7:0]  ptw_resolve_access_bits;
    logic [21:0] ptw_resolve_physical_address;
`ifdef COREVX_TLB_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // results of the most recent transaction
    logic        r_got;
    logic [21:0] r_ppn;
    logic [7:0]  r_bits;
    logic        r_pf;
    logic        r_af;
    logic        r_ptw;
    int          r_lat;

    corevx_tlb dut (
        .clk                          (clk),
        .rst                          (rst),
        .req_valid                    (req_valid),
        .req_vpn                      (req_vpn),
        .req_cmd                      (req_cmd),
        .req_user                     (req_user),
        .req_ready                    (req_ready),
        .resp_valid                   (resp_valid),
        .resp_ppn                     (resp_ppn),
        .resp_access_bits             (resp_access_bits),
        .resp_pagefault               (resp_pagefault),
        .resp_accessfault             (resp_accessfault),
        .satp_mode                    (satp_mode),
        .flush                        (flush),
        .ptw_resolve_request          (ptw_resolve_request),
        .ptw_resolve_ack              (ptw_resolve_ack),
        .ptw_virtual_address          (ptw_virtual_address),
        .ptw_resolve_done             (ptw_resolve_done),
        .ptw_resolve_pagefault        (ptw_resolve_pagefault),
        .ptw_resolve_accessfault      (ptw_resolve_accessfault),
        .ptw_resolve_access_bits      (ptw_resolve_access_bits),
        .ptw_resolve_physical_address (ptw_resolve_physical_address)
`ifdef COREVX_TLB_STATS_EN
        ,
        .stat_hits                    (stat_hits),
        .stat_misses                  (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; the scripted PTW acks one cycle after seeing the request
    // and returns done two cycles after the ack. Optional flush in REFILL_WAIT.
    task automatic xact(input logic [19:0] vpn, input logic [1:0] cmd, input logic user,
                        input logic [21:0] p_ppn, input logic [7:0] p_bits,
                        input logic p_pf, input logic p_af, input logic flush_wait);
        int phase;
        logic got;
        @(negedge clk);
        req_vpn   = vpn;
        req_cmd   = cmd;
        req_user  = user;
        req_valid = 1'b1;
        #1;
        chk("req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        phase = 0;
        got   = 1'b0;
        r_ptw = 1'b0;
        r_lat = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            ptw_resolve_ack              = (phase == 1);
            ptw_resolve_done             = (phase == 3);
            ptw_resolve_pagefault        = p_pf;
            ptw_resolve_accessfault      = p_af;
            ptw_resolve_access_bits      = p_bits;
            ptw_resolve_physical_address = p_ppn;
            flush                        = flush_wait && (phase == 2);
            #1;
            if (flush) chk("ready_in_flush", req_ready, 0);
            if (resp_valid) begin
                got    = 1'b1;
                r_lat  = i;
                r_ppn  = resp_ppn;
                r_bits = resp_access_bits;
                r_pf   = resp_pagefault;
                r_af   = resp_accessfault;
            end else if (phase == 0 && ptw_resolve_request) begin
                r_ptw = 1'b1;
                chk("ptw_va", ptw_virtual_address, vpn);
                phase = 1;
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2) begin
                phase = 3;
            end
        end
        @(posedge clk);
        #1;
        ptw_resolve_ack  = 1'b0;
        ptw_resolve_done = 1'b0;
        flush            = 1'b0;
        r_got = got;
        chk("resp_seen", r_got, 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_vpn = '0; req_cmd = 2'b01; req_user = 1'b0;
        satp_mode = 1'b1; flush = 1'b0;
        ptw_resolve_ack = 1'b0; ptw_resolve_done = 1'b0;
        ptw_resolve_pagefault = 1'b0; ptw_resolve_accessfault = 1'b0;
        ptw_resolve_access_bits = '0; ptw_resolve_physical_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  req_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_ptwreq", ptw_resolve_request, 0);
        chk("rst_ppn",    resp_ppn, 0);
        chk("rst_bits",   resp_access_bits, 0);
        chk("rst_pf",     resp_pagefault, 0);
        chk("rst_af",     resp_accessfault, 0);
        rst = 1'b0;

        // 1: miss then hit on VPN 0x12345
        xact(20'h12345, 2'b01, 1'b0, 22'h0ABCD, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("t1_ptw",  r_ptw, 1);
        chk("t1_ppn",  r_ppn, 22'h0ABCD);
        chk("t1_bits", r_bits, 8'h4F);
        chk("t1_pf",   r_pf, 0);
        chk("t1_af",   r_af, 0);
        xact(20'h12345, 2'b01, 1'b0, 22'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("t1h_ptw", r_ptw, 0);
        chk("t1h_lat", r_lat, 1);
        chk("t1h_ppn", r_ppn, 22'h0ABCD);
        chk("t1h_pf",  r_pf, 0);
        @(negedge clk);
        chk("hold_rvalid", resp_valid, 0);
        chk("hold_ppn",    resp_ppn, 22'h0ABCD);
        chk("hold_bits",   resp_access_bits, 8'h4F);

        // 2: write with D=0 faults; entry stays valid
        xact(20'h12345, 2'b10, 1'b0, 22'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("t2w_ptw", r_ptw, 0);
        chk("t2w_pf",  r_pf, 1);
        chk("t2w_af",  r_af, 0);
        xact(20'h12345, 2'b01, 1'b0, 22'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("t2r_ptw", r_ptw, 0);
        chk("t2r_pf",  r_pf, 0);
        xact(20'h12345, 2'b01, 1'b1, 22'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("user_pf", r_pf, 1);
        xact(20'h12345, 2'b11, 1'b0, 22'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("exec_pf", r_pf, 0);
        chk("exec_ptw", r_ptw, 0);

        // 3: PTW accessfault and pagefault are reported and not installed
        xact(20'h00010, 2'b01, 1'b0, 22'h00111, 8'h4F, 1'b1, 1'b1, 1'b0);
        chk("t3_af",  r_af, 1);
        chk("t3_pf",  r_pf, 0);
        xact(20'h00010, 2'b01, 1'b0, 22'h00111, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("t3_reptw", r_ptw, 1);
        chk("t3_reppn", r_ppn, 22'h00111);
        xact(20'h00020, 2'b01, 1'b0, 22'h00222, 8'h4F, 1'b1, 1'b0, 1'b0);
        chk("t3p_pf", r_pf, 1);
        chk("t3p_af", r_af, 0);
        xact(20'h00020, 2'b01, 1'b0, 22'h00222, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("t3p_reptw", r_ptw, 1);

        // 4: same-index eviction
        xact(20'h00001, 2'b01, 1'b0, 22'h00A01, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("t4a_ptw", r_ptw, 1);
        xact(20'h00011, 2'b01, 1'b0, 22'h00A11, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("t4b_ptw", r_ptw, 1);
        chk("t4b_ppn", r_ppn, 22'h00A11);
        xact(20'h00001, 2'b01, 1'b0, 22'h00A01, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("t4c_ptw", r_ptw, 1);

        // 5: flush during REFILL_WAIT still responds but does not install
        xact(20'h00005, 2'b01, 1'b0, 22'h00B05, 8'h4F, 1'b0, 1'b0, 1'b1);
        chk("t5_ppn", r_ppn, 22'h00B05);
        chk("t5_pf",  r_pf, 0);
        xact(20'h00005, 2'b01, 1'b0, 22'h00B05, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("t5_reptw", r_ptw, 1);

        // flush together with req_valid in IDLE: not accepted, entries cleared
        @(negedge clk);
        req_vpn = 20'h00011; req_cmd = 2'b01; req_user = 1'b0;
        req_valid = 1'b1; flush = 1'b1;
        #1;
        chk("idle_flush_ready", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        chk("idle_flush_noacc", req_ready, 1);
        chk("idle_flush_noresp", resp_valid, 0);
        @(negedge clk);
        chk("idle_flush_noptw", ptw_resolve_request, 0);
        xact(20'h00011, 2'b01, 1'b0, 22'h00A11, 8'h4F, 1'b0, 1'b0, 1'b0);
        chk("flushed_miss", r_ptw, 1);

        // 6: bare mode
        satp_mode = 1'b0;
        xact(20'hFFFFF, 2'b10, 1'b1, 22'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("bare_ptw",  r_ptw, 0);
        chk("bare_lat",  r_lat, 1);
        chk("bare_ppn",  r_ppn, 22'h0FFFFF);
        chk("bare_bits", r_bits, 8'hFF);
        chk("bare_pf",   r_pf, 0);
        chk("bare_af",   r_af, 0);
        satp_mode = 1'b1;

`ifdef COREVX_TLB_STATS_EN
        @(negedge clk);
        chk("stat_hits",   stat_hits, 32'd5);
        chk("stat_misses", stat_misses, 32'd11);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
